mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester byte-serial memory arbiter: instruction fetch (word reads) and
// data accesses (1/2/4-byte reads and writes) share one 8-bit RAM port.
module mem_arbiter #(
  parameter logic MEM_PRIORITY = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic        mem_stall_req,
  output logic [31:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_RD  = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [2:0]  c_r, c_s;
  logic [2:0]  n_r, n_s;
  logic [31:0] base_r, base_s;
  logic [31:0] wdata_r, wdata_s;
  logic [31:0] buf_r, buf_s;
  logic [31:0] if_data_r, if_data_s;
  logic [31:0] mem_rdata_r, mem_rdata_s;
  logic        if_done_r, if_done_s;
  logic        mem_done_r, mem_done_s;
  logic [31:0] ram_a_r, ram_a_s;
  logic [7:0]  ram_dout_r, ram_dout_s;
  logic        wr_act_r, wr_act_s;

  logic        if_ok_s;
  logic        mem_ok_s;
  logic        grant_mem_s;
  logic [2:0]  c_inc_s;
  logic [31:0] capt_s;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] w;
    w = word;
    case (idx)
      2'd0:    w[7:0]   = b;
      2'd1:    w[15:8]  = b;
      2'd2:    w[23:16] = b;
      default: w[31:24] = b;
    endcase
    return w;
  endfunction

  // A requester whose done pulse is showing this cycle is masked so a held request is not re-granted.
  always_comb begin
    if_ok_s     = if_req & ~if_flush & ~if_done_r;
    mem_ok_s    = mem_req & ~mem_done_r;
    grant_mem_s = mem_ok_s & (MEM_PRIORITY | ~if_ok_s);
    c_inc_s     = c_r + 3'd1;
    capt_s      = put_byte(buf_r, c_r[1:0] - 2'd1, ram_din);
  end

  // Next-state and datapath update; every register holds unless rdy allows a step.
  always_comb begin
    state_s     = state_r;
    c_s         = c_r;
    n_s         = n_r;
    base_s      = base_r;
    wdata_s     = wdata_r;
    buf_s       = buf_r;
    if_data_s   = if_data_r;
    mem_rdata_s = mem_rdata_r;
    if_done_s   = if_done_r;
    mem_done_s  = mem_done_r;
    ram_a_s     = ram_a_r;
    ram_dout_s  = ram_dout_r;
    wr_act_s    = wr_act_r;

    if (rdy) begin
      if_done_s  = 1'b0;
      mem_done_s = 1'b0;
    end else begin
      if_done_s  = if_done_r;
      mem_done_s = mem_done_r;
    end

    case (state_r)
      IDLE: begin
        if (rdy && grant_mem_s) begin
          state_s    = mem_we ? MEM_WR : MEM_RD;
          c_s        = 3'd0;
          n_s        = size_bytes(mem_size);
          base_s     = mem_addr;
          wdata_s    = mem_wdata;
          buf_s      = 32'd0;
          ram_a_s    = mem_addr;
          ram_dout_s = mem_wdata[7:0];
          wr_act_s   = mem_we;
        end else if (rdy && if_ok_s) begin
          state_s  = IF_RD;
          c_s      = 3'd0;
          n_s      = 3'd4;
          base_s   = if_addr;
          buf_s    = 32'd0;
          ram_a_s  = if_addr;
          wr_act_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      IF_RD, MEM_RD: begin
        if (state_r == IF_RD && if_flush) begin
          state_s = IDLE;
          c_s     = 3'd0;
        end else if (rdy) begin
          // Byte k arrives one cycle after its address, so capture lags the counter by one.
          if (c_r != 3'd0) begin
            buf_s = capt_s;
          end else begin
            buf_s = buf_r;
          end
          if (c_r == n_r) begin
            state_s = IDLE;
            c_s     = 3'd0;
            if (state_r == IF_RD) begin
              if_data_s = capt_s;
              if_done_s = 1'b1;
            end else begin
              mem_rdata_s = capt_s;
              mem_done_s  = 1'b1;
            end
          end else begin
            c_s     = c_inc_s;
            ram_a_s = base_r + {29'd0, c_inc_s};
          end
        end else begin
          state_s = state_r;
        end
      end
      MEM_WR: begin
        if (rdy) begin
          if (c_inc_s == n_r) begin
            state_s    = IDLE;
            c_s        = 3'd0;
            wr_act_s   = 1'b0;
            mem_done_s = 1'b1;
          end else begin
            c_s        = c_inc_s;
            ram_a_s    = base_r + {29'd0, c_inc_s};
            ram_dout_s = byte_of(wdata_r, c_inc_s[1:0]);
          end
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s  = IDLE;
        c_s      = 3'd0;
        wr_act_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      c_r         <= 3'd0;
      n_r         <= 3'd0;
      base_r      <= 32'd0;
      wdata_r     <= 32'd0;
      buf_r       <= 32'd0;
      if_data_r   <= 32'd0;
      mem_rdata_r <= 32'd0;
      if_done_r   <= 1'b0;
      mem_done_r  <= 1'b0;
      ram_a_r     <= 32'd0;
      ram_dout_r  <= 8'd0;
      wr_act_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      c_r         <= c_s;
      n_r         <= n_s;
      base_r      <= base_s;
      wdata_r     <= wdata_s;
      buf_r       <= buf_s;
      if_data_r   <= if_data_s;
      mem_rdata_r <= mem_rdata_s;
      if_done_r   <= if_done_s;
      mem_done_r  <= mem_done_s;
      ram_a_r     <= ram_a_s;
      ram_dout_r  <= ram_dout_s;
      wr_act_r    <= wr_act_s;
    end
  end

  // rdy gates strobes and pulses directly so a frozen cycle never writes or signals.
  assign if_done       = if_done_r & rdy;
  assign mem_done      = mem_done_r & rdy;
  assign ram_wr        = wr_act_r & rdy;
  assign if_data       = if_data_r;
  assign mem_rdata     = mem_rdata_r;
  assign ram_a         = ram_a_r;
  assign ram_dout      = ram_dout_r;
  assign mem_stall_req = mem_req & ~mem_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed accesses push expected done
// cycles/data and RAM writes; a forked monitor pops and compares.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_flush = 1'b0;
  logic        if_done;
  logic [31:0] if_data;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        mem_stall_req;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din = 8'd0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct { logic [31:0] data; int cyc; bit chk; } exp_t;
  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
  exp_t if_q[$];
  exp_t mem_q[$];
  wr_t  wr_q[$];

  logic [7:0] ram [0:65535];

  mem_arbiter #(.MEM_PRIORITY(1'b1)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_stall_req(mem_stall_req),
    .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    case (a)
      32'h100: return 8'h13;
      32'h101: return 8'h05;
      32'h102: return 8'h10;
      32'h103: return 8'h00;
      32'h200: return 8'h93;
      32'h201: return 8'h00;
      32'h202: return 8'h10;
      32'h203: return 8'h00;
      default: return ram[a[15:0]];
    endcase
  endfunction

  // Synchronous byte RAM: read data one cycle after the address, held while rdy=0.
  always @(posedge clk) begin
    if (ram_wr) ram[ram_a[15:0]] <= ram_dout;
    if (rdy) ram_din <= rd_byte(ram_a);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    wr_t  w;
    forever begin
      @(negedge clk);
      if (if_done) begin
        if (if_q.size() == 0) check("if_done_spurious", {31'd0, if_done}, 32'd0);
        else begin
          e = if_q.pop_front();
          check("if_done_cycle", cyc, e.cyc);
          if (e.chk) check("if_data", if_data, e.data);
        end
      end
      if (mem_done) begin
        if (mem_q.size() == 0) check("mem_done_spurious", {31'd0, mem_done}, 32'd0);
        else begin
          e = mem_q.pop_front();
          check("mem_done_cycle", cyc, e.cyc);
          check("mem_stall_in_done", {31'd0, mem_stall_req}, 32'd0);
          if (e.chk) check("mem_rdata", mem_rdata, e.data);
        end
      end
      if (ram_wr) begin
        if (wr_q.size() == 0) check("ram_wr_spurious", {31'd0, ram_wr}, 32'd0);
        else begin
          w = wr_q.pop_front();
          check("ram_wr_addr", ram_a, w.a);
          check("ram_wr_data", {24'd0, ram_dout}, {24'd0, w.d});
          check("ram_wr_rdy", {31'd0, rdy}, 32'd1);
        end
      end
    end
  endtask

  // Drops each request the cycle after its done; optional rdy gap relative to the start cycle.
  task automatic serve(input int budget, input int gap_at, input int gap_len);
    int i;
    bit idn, mdn;
    i = 0;
    while ((if_req || mem_req) && i < budget) begin
      @(negedge clk);
      idn = if_done;
      mdn = mem_done;
      @(posedge clk);
      #1;
      if (idn) if_req = 1'b0;
      if (mdn) mem_req = 1'b0;
      i++;
      rdy = !(gap_len > 0 && i >= gap_at && i < gap_at + gap_len);
    end
    if (if_req || mem_req) begin
      check("serve_timeout", {30'd0, if_req, mem_req}, 32'd0);
      if_req = 1'b0;
      mem_req = 1'b0;
    end
    rdy = 1'b1;
  endtask

  task automatic push_exp(input bit to_if, input logic [31:0] d, input int c, input bit chk);
    exp_t e;
    e.data = d; e.cyc = c; e.chk = chk;
    if (to_if) if_q.push_back(e);
    else mem_q.push_back(e);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a; w.d = d;
    wr_q.push_back(w);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ram_a"}, ram_a, 32'd0);
    check({tag, "_ram_dout"}, {24'd0, ram_dout}, 32'd0);
    check({tag, "_ram_wr"}, {31'd0, ram_wr}, 32'd0);
    check({tag, "_if_done"}, {31'd0, if_done}, 32'd0);
    check({tag, "_mem_done"}, {31'd0, mem_done}, 32'd0);
    check({tag, "_if_data"}, if_data, 32'd0);
    check({tag, "_mem_rdata"}, mem_rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Word fetch of 0x100
    t = cyc;
    if_addr = 32'h100;
    if_req = 1'b1;
    push_exp(1'b1, 32'h0010_0513, t + 6, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("fetch_ram_a", ram_a, 32'h100 + k);
    end
    serve(20, 0, 0);

    // Byte write of 0xAB then byte read back
    t = cyc;
    mem_addr = 32'h2000; mem_wdata = 32'h1234_56AB; mem_size = 2'b00; mem_we = 1'b1;
    mem_req = 1'b1;
    push_wr(32'h2000, 8'hAB);
    push_exp(1'b0, 32'd0, t + 2, 1'b0);
    serve(20, 0, 0);
    t = cyc;
    mem_we = 1'b0;
    mem_req = 1'b1;
    push_exp(1'b0, 32'h0000_00AB, t + 3, 1'b1);
    serve(20, 0, 0);

    // Word write with a 3-cycle rdy gap
    t = cyc;
    mem_addr = 32'h3000; mem_wdata = 32'hDEAD_BEEF; mem_size = 2'b10; mem_we = 1'b1;
    mem_req = 1'b1;
    push_wr(32'h3000, 8'hEF);
    push_wr(32'h3001, 8'hBE);
    push_wr(32'h3002, 8'hAD);
    push_wr(32'h3003, 8'hDE);
    push_exp(1'b0, 32'd0, t + 8, 1'b0);
    serve(30, 2, 3);

    // Contention: mem (size 11 = word) first, fetch granted in the mem_done cycle
    t = cyc;
    mem_addr = 32'h3000; mem_size = 2'b11; mem_we = 1'b0;
    if_addr = 32'h100;
    mem_req = 1'b1;
    if_req = 1'b1;
    push_exp(1'b0, 32'hDEAD_BEEF, t + 6, 1'b1);
    push_exp(1'b1, 32'h0010_0513, t + 12, 1'b1);
    serve(40, 0, 0);

    // Halfword read, zero-extended
    t = cyc;
    mem_addr = 32'h3002; mem_size = 2'b01; mem_we = 1'b0;
    mem_req = 1'b1;
    push_exp(1'b0, 32'h0000_DEAD, t + 4, 1'b1);
    serve(20, 0, 0);

    // Flush at T+3, redirect to 0x200 granted from IDLE at T+4
    t = cyc;
    if_addr = 32'h100;
    if_req = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    if_flush = 1'b1;
    if_addr = 32'h200;
    @(posedge clk);
    #1;
    if_flush = 1'b0;
    push_exp(1'b1, 32'h0010_0093, t + 10, 1'b1);
    serve(30, 0, 0);

    // Reset in the middle of a word read
    t = cyc;
    mem_addr = 32'h100; mem_size = 2'b10; mem_we = 1'b0;
    mem_req = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    check("midreset_stall", {31'd0, mem_stall_req}, 32'd1);
    mem_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Resumes from IDLE after reset
    t = cyc;
    if_addr = 32'h200;
    if_req = 1'b1;
    push_exp(1'b1, 32'h0010_0093, t + 6, 1'b1);
    serve(20, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("if_q_left", if_q.size(), 32'd0);
    check("mem_q_left", mem_q.size(), 32'd0);
    check("wr_q_left", wr_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
